load_use_hazard_unit: RTL and testbench

LOAD_USE_HAZARD_UNIT -- requirements
Module: load_use_hazard_unit

---
 rtl/load_use_hazard_if.sv | 33 +++
 rtl/load_use_hazard_unit.sv | 81 ++++++++
 tb/tb_load_use_hazard_unit.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/load_use_hazard_if.sv
// ID-stage hazard bundle: decoded ID operands and pipeline controls in,
// stall/bubble/issue decisions and the bubble counter out.
interface load_use_hazard_if #(
  parameter int CNT_W = 16
);
  logic             id_valid;
  logic [4:0]       id_rs1_addr;
  logic [4:0]       id_rs2_addr;
  logic             id_rs1_used;
  logic             id_rs2_used;
  logic [4:0]       id_rd;
  logic             id_reg_write;
  logic             id_late;
  logic             mem_stall;
  logic             ex_busy;
  logic             flush_all;
  logic             stall_id;
  logic             bubble_ex;
  logic             id_issue;
  logic [CNT_W-1:0] stall_cnt;

  modport master (
    output id_valid, id_rs1_addr, id_rs2_addr, id_rs1_used, id_rs2_used,
           id_rd, id_reg_write, id_late, mem_stall, ex_busy, flush_all,
    input  stall_id, bubble_ex, id_issue, stall_cnt
  );

  modport slave (
    input  id_valid, id_rs1_addr, id_rs2_addr, id_rs1_used, id_rs2_used,
           id_rd, id_reg_write, id_late, mem_stall, ex_busy, flush_all,
    output stall_id, bubble_ex, id_issue, stall_cnt
  );
endinterface

// File: rtl/load_use_hazard_unit.sv
// Load-use hazard detector: per-register down-counter scoreboard of late results,
// combinational stall/bubble/issue decisions and a saturating bubble counter.
module load_use_hazard_unit #(
  parameter int LATE_LAT = 3,
  parameter int CNT_W    = 16
) (
  input logic              clk,
  input logic              rst,
  load_use_hazard_if.slave bus
);

  localparam logic [1:0] LATE_INIT = 2'(LATE_LAT);

  logic [31:0][1:0] pend_q;
  logic [31:0][1:0] pend_d;
  logic [CNT_W-1:0] stall_cnt_q;
  logic [CNT_W-1:0] stall_cnt_d;

  logic freeze;
  logic rs1_busy;
  logic rs2_busy;
  logic hazard;
  logic stall_id;
  logic bubble_ex;
  logic id_issue;
  logic rd_write;

  // Sources read the pre-update scoreboard, so an op whose rs equals its rd never waits on itself.
  always_comb begin
    freeze    = bus.mem_stall | bus.ex_busy;
    rs1_busy  = bus.id_rs1_used && (bus.id_rs1_addr != 5'd0) &&
                (pend_q[bus.id_rs1_addr] != 2'd0);
    rs2_busy  = bus.id_rs2_used && (bus.id_rs2_addr != 5'd0) &&
                (pend_q[bus.id_rs2_addr] != 2'd0);
    hazard    = bus.id_valid && (rs1_busy || rs2_busy);
    stall_id  = hazard | freeze;
    bubble_ex = hazard & ~freeze & ~bus.flush_all;
    id_issue  = bus.id_valid & ~stall_id & ~bus.flush_all;
    rd_write  = id_issue & bus.id_reg_write & (bus.id_rd != 5'd0);
  end

  assign bus.stall_id  = stall_id;
  assign bus.bubble_ex = bubble_ex;
  assign bus.id_issue  = id_issue;
  assign bus.stall_cnt = stall_cnt_q;

  // Flush beats everything; an issuing writer overrides the age-out of its rd.
  always_comb begin
    pend_d = pend_q;
    for (int r = 1; r < 32; r++) begin
      if (bus.flush_all) begin
        pend_d[r] = 2'd0;
      end else if (!freeze) begin
        if (rd_write && (bus.id_rd == 5'(r))) begin
          pend_d[r] = bus.id_late ? LATE_INIT : 2'd0;
        end else if (pend_q[r] != 2'd0) begin
          pend_d[r] = pend_q[r] - 2'd1;
        end
      end
    end
    pend_d[0] = 2'd0;
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (bubble_ex && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_q      <= '0;
      stall_cnt_q <= '0;
    end else begin
      pend_q      <= pend_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

endmodule

// File: tb/tb_load_use_hazard_unit.sv
// Bench for load_use_hazard_unit: ready-time model checked every cycle plus directed scenarios.
module tb_load_use_hazard_unit;

  localparam int LATE_LAT = 3;
  localparam int CNT_W    = 2;
  localparam int CNT_MAX  = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  load_use_hazard_if #(.CNT_W(CNT_W)) bus ();

  load_use_hazard_unit #(.LATE_LAT(LATE_LAT), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Model: a register is ready once enough unfrozen cycles have elapsed since its late producer issued.
  longint adv = 0;
  longint ready_at [32] = '{default: 0};
  int     m_cnt = 0;

  function automatic bit m_busy(input logic [4:0] r);
    return (r != 5'd0) && (ready_at[r] > adv);
  endfunction

  function automatic bit m_hazard();
    return bus.id_valid && ((bus.id_rs1_used && m_busy(bus.id_rs1_addr)) ||
                            (bus.id_rs2_used && m_busy(bus.id_rs2_addr)));
  endfunction

  function automatic bit m_freeze();
    return bus.mem_stall || bus.ex_busy;
  endfunction

  function automatic bit m_bubble();
    return m_hazard() && !m_freeze() && !bus.flush_all;
  endfunction

  function automatic bit m_issue();
    return bus.id_valid && !(m_hazard() || m_freeze()) && !bus.flush_all;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      adv = 0;
      for (int i = 0; i < 32; i++) ready_at[i] = 0;
      m_cnt = 0;
    end else begin : upd
      bit bub;
      bit iss;
      bub = m_bubble();
      iss = m_issue();
      if (bub && m_cnt < CNT_MAX) m_cnt++;
      if (bus.flush_all) begin
        adv++;
        for (int i = 0; i < 32; i++) ready_at[i] = 0;
      end else if (!m_freeze()) begin
        adv++;
        if (iss && bus.id_reg_write && bus.id_rd != 5'd0)
          ready_at[bus.id_rd] = bus.id_late ? adv + LATE_LAT : 0;
      end
    end
  end

  always @(negedge clk) begin
    check("cyc_stall_id",  32'(bus.stall_id),  32'(m_hazard() || m_freeze()));
    check("cyc_bubble_ex", 32'(bus.bubble_ex), 32'(m_bubble()));
    check("cyc_id_issue",  32'(bus.id_issue),  32'(m_issue()));
    check("cyc_stall_cnt", 32'(bus.stall_cnt), 32'(m_cnt));
  end

  task automatic set_id(input bit v, input int rs1, input bit u1, input int rs2, input bit u2,
                        input int rd, input bit rw, input bit late);
    bus.id_valid     = v;
    bus.id_rs1_addr  = 5'(rs1);
    bus.id_rs1_used  = u1;
    bus.id_rs2_addr  = 5'(rs2);
    bus.id_rs2_used  = u2;
    bus.id_rd        = 5'(rd);
    bus.id_reg_write = rw;
    bus.id_late      = late;
  endtask

  task automatic set_idle();
    set_id(0, 0, 0, 0, 0, 0, 0, 0);
    bus.mem_stall = 1'b0;
    bus.ex_busy   = 1'b0;
    bus.flush_all = 1'b0;
  endtask

  // Called at posedge+1; samples mid-cycle, returns at the next posedge+1.
  task automatic cyc(input string tag, input bit s, input bit b, input bit i);
    #2;
    check({tag, "_stall_id"},  32'(bus.stall_id),  32'(s));
    check({tag, "_bubble_ex"}, 32'(bus.bubble_ex), 32'(b));
    check({tag, "_id_issue"},  32'(bus.id_issue),  32'(i));
    @(posedge clk); #1;
  endtask

  task automatic reset_dut();
    set_idle();
    #1 rst = 1'b1;
    #2 rst = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    set_idle();
    @(posedge clk); #1;

    // Reset state and load-use with three bubbles
    reset_dut();
    check("rst_stall_cnt", 32'(bus.stall_cnt), 32'd0);
    check("rst_stall_id",  32'(bus.stall_id),  32'd0);
    set_id(1, 0, 0, 0, 0, 5, 1, 1);  cyc("s1_lw", 0, 0, 1);
    set_id(1, 5, 1, 1, 1, 6, 1, 0);
    cyc("s1_b1", 1, 1, 0); cyc("s1_b2", 1, 1, 0); cyc("s1_b3", 1, 1, 0);
    cyc("s1_go", 0, 0, 1);
    set_idle(); cyc("s1_idle", 0, 0, 0);
    check("s1_stall_cnt", 32'(bus.stall_cnt), 32'd3);

    // Freeze in the middle of a hazard
    reset_dut();
    set_id(1, 0, 0, 0, 0, 5, 1, 1);  cyc("s2_lw", 0, 0, 1);
    set_id(1, 5, 1, 1, 1, 6, 1, 0);
    cyc("s2_b1", 1, 1, 0);
    bus.mem_stall = 1'b1;
    cyc("s2_f1", 1, 0, 0); cyc("s2_f2", 1, 0, 0);
    bus.mem_stall = 1'b0;
    cyc("s2_b2", 1, 1, 0); cyc("s2_b3", 1, 1, 0);
    cyc("s2_go", 0, 0, 1);
    set_idle(); cyc("s2_idle", 0, 0, 0);
    check("s2_stall_cnt", 32'(bus.stall_cnt), 32'd3);

    // WAW override and self-dependency
    reset_dut();
    set_id(1, 0, 0, 0, 0, 7, 1, 1);  cyc("s3_lw7", 0, 0, 1);
    set_id(1, 1, 1, 0, 0, 7, 1, 0);  cyc("s3_addi7", 0, 0, 1);
    set_id(1, 7, 1, 2, 1, 8, 1, 0);  cyc("s3_use7", 0, 0, 1);
    set_id(1, 4, 1, 0, 0, 4, 1, 1);  cyc("s3_lw4self", 0, 0, 1);
    set_id(1, 0, 0, 4, 1, 9, 1, 0);  cyc("s3_use4", 1, 1, 0);
    set_idle(); cyc("s3_idle", 0, 0, 0);

    // x0 and unused sources never stall
    reset_dut();
    set_id(1, 0, 0, 0, 0, 0, 1, 1);  cyc("s4_lw0", 0, 0, 1);
    set_id(1, 0, 1, 0, 1, 6, 1, 0);  cyc("s4_use0", 0, 0, 1);
    set_id(1, 0, 0, 0, 0, 9, 1, 1);  cyc("s4_csr9", 0, 0, 1);
    set_id(1, 2, 1, 9, 0, 6, 1, 0);  cyc("s4_unused9", 0, 0, 1);
    set_id(1, 2, 1, 9, 1, 6, 1, 0);  cyc("s4_used9", 1, 1, 0);
    set_idle(); cyc("s4_idle", 0, 0, 0);

    // Flush kills the pending load
    reset_dut();
    set_id(1, 0, 0, 0, 0, 3, 1, 1);  cyc("s5_lw3", 0, 0, 1);
    set_id(1, 3, 1, 0, 0, 6, 1, 0);
    bus.flush_all = 1'b1;            cyc("s5_flush", 1, 0, 0);
    bus.flush_all = 1'b0;            cyc("s5_go", 0, 0, 1);
    set_idle(); cyc("s5_idle", 0, 0, 0);

    // ex_busy freezes an idle and a hazarded ID alike
    reset_dut();
    bus.ex_busy = 1'b1;              cyc("s7_idle_frz", 1, 0, 0);
    bus.ex_busy = 1'b0;
    set_id(1, 0, 0, 0, 0, 5, 1, 1);  cyc("s7_lw", 0, 0, 1);
    set_id(1, 0, 0, 5, 1, 6, 1, 0);
    bus.ex_busy = 1'b1;              cyc("s7_frz", 1, 0, 0);
    bus.ex_busy = 1'b0;
    cyc("s7_b1", 1, 1, 0); cyc("s7_b2", 1, 1, 0); cyc("s7_b3", 1, 1, 0);
    cyc("s7_go", 0, 0, 1);
    set_idle(); cyc("s7_idle", 0, 0, 0);

    // Counter saturation, then asynchronous reset mid-stall
    reset_dut();
    set_id(1, 0, 0, 0, 0, 5, 1, 1);  cyc("s6_lw5", 0, 0, 1);
    set_id(1, 5, 1, 0, 0, 6, 1, 0);
    cyc("s6_b1", 1, 1, 0); cyc("s6_b2", 1, 1, 0); cyc("s6_b3", 1, 1, 0);
    set_id(1, 0, 0, 0, 0, 8, 1, 1);  cyc("s6_lw8", 0, 0, 1);
    set_id(1, 8, 1, 0, 0, 6, 1, 0);
    cyc("s6_b4", 1, 1, 0); cyc("s6_b5", 1, 1, 0);
    #2;
    check("s6_sat_cnt",      32'(bus.stall_cnt), 32'd3);
    check("s6_pre_rst_stall", 32'(bus.stall_id), 32'd1);
    rst = 1'b1;
    #1;
    check("s6_rst_cnt",    32'(bus.stall_cnt), 32'd0);
    check("s6_rst_stall",  32'(bus.stall_id),  32'd0);
    check("s6_rst_bubble", 32'(bus.bubble_ex), 32'd0);
    check("s6_rst_issue",  32'(bus.id_issue),  32'd1);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    cyc("s6_after", 0, 0, 1);
    set_idle(); cyc("s6_idle", 0, 0, 0);
    check("s6_end_cnt", 32'(bus.stall_cnt), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
